// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle controller: opcodes, ALU operation classes and FSM states.
package multicycle_ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_t;

    function automatic logic op_legal(input logic [6:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH: legal = 1'b1;
            default:                                  legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/multicycle_ctrl.sv
// Multicycle datapath control FSM: R/I/STORE 4 cycles, LOAD 5, BRANCH 3; stalls in FETCH/MEM until mem_ready_i.
// Optional MULTICYCLE_CTRL_TIMEOUT_EN bounds memory waits to MEM_TIMEOUT cycles, aborting to IDLE with sticky timeout_o.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       halt_i,
    input  logic [6:0] Op_i,
    input  logic       Zero_i,
    input  logic       mem_ready_i,
    output logic       PCWrite_o,
    output logic       IRWrite_o,
    output logic       MemRead_o,
    output logic       MemWrite_o,
    output logic       MemtoReg_o,
    output logic       ALUSrc_o,
    output logic       RegWrite_o,
    output logic       Branch_o,
    output logic [1:0] ALUOp_o,
    output logic       retire_o,
    output logic       illegal_o,
`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
    output logic       timeout_o,
`endif
    output logic [2:0] state_o
);

    // The wait counter is 4 bits wide, so only limits of 1..15 are meaningful.
    if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 15) begin : g_bad_mem_timeout
        $error("multicycle_ctrl: MEM_TIMEOUT must be in 1..15");
    end

    state_t     state;
    logic [6:0] opcode;
    logic       illegal;
    logic       timeout_hit;

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
    localparam logic [3:0] WAIT_LIMIT = 4'(MEM_TIMEOUT - 1);

    logic [3:0] wait_cnt;
    logic       timeout;
    logic       mem_wait;

    assign mem_wait    = ((state == ST_FETCH) || (state == ST_MEM)) && !mem_ready_i;
    assign timeout_hit = mem_wait && (wait_cnt == WAIT_LIMIT);
    assign timeout_o   = timeout;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wait_cnt <= '0;
            timeout  <= 1'b0;
        end else if (timeout_hit) begin
            wait_cnt <= '0;
            timeout  <= 1'b1;
        end else if (mem_wait) begin
            wait_cnt <= wait_cnt + 4'd1;
        end else begin
            wait_cnt <= '0;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            opcode  <= '0;
            illegal <= 1'b0;
        end else if (timeout_hit) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (mem_ready_i) state <= ST_DECODE;
                end
                ST_DECODE: begin
                    opcode <= Op_i;
                    if (op_legal(Op_i)) begin
                        state <= ST_EXEC;
                    end else begin
                        illegal <= 1'b1;
                        state   <= halt_i ? ST_IDLE : ST_FETCH;
                    end
                end
                // From here on only the latched opcode steers the sequence.
                ST_EXEC: begin
                    case (opcode)
                        OP_R, OP_I:         state <= ST_WB;
                        OP_LOAD, OP_STORE:  state <= ST_MEM;
                        OP_BRANCH:          state <= halt_i ? ST_IDLE : ST_FETCH;
                        default:            state <= ST_IDLE;
                    endcase
                end
                ST_MEM: begin
                    if (mem_ready_i) begin
                        if (opcode == OP_LOAD) state <= ST_WB;
                        else                   state <= halt_i ? ST_IDLE : ST_FETCH;
                    end
                end
                ST_WB: begin
                    state <= halt_i ? ST_IDLE : ST_FETCH;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        PCWrite_o  = 1'b0;
        IRWrite_o  = 1'b0;
        MemRead_o  = 1'b0;
        MemWrite_o = 1'b0;
        MemtoReg_o = 1'b0;
        ALUSrc_o   = 1'b0;
        RegWrite_o = 1'b0;
        Branch_o   = 1'b0;
        ALUOp_o    = ALU_ADD;
        retire_o   = 1'b0;
        case (state)
            ST_FETCH: begin
                MemRead_o = 1'b1;
                if (mem_ready_i) begin
                    PCWrite_o = 1'b1;
                    IRWrite_o = 1'b1;
                end
            end
            ST_DECODE: begin
                retire_o = !op_legal(Op_i);
            end
            ST_EXEC: begin
                case (opcode)
                    OP_R: ALUOp_o = ALU_FUNCT;
                    OP_I: begin
                        ALUOp_o  = ALU_FUNCT;
                        ALUSrc_o = 1'b1;
                    end
                    OP_LOAD, OP_STORE: begin
                        ALUOp_o  = ALU_ADD;
                        ALUSrc_o = 1'b1;
                    end
                    OP_BRANCH: begin
                        ALUOp_o   = ALU_SUB;
                        Branch_o  = 1'b1;
                        PCWrite_o = Zero_i;
                        retire_o  = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_MEM: begin
                ALUSrc_o   = 1'b1;
                MemRead_o  = (opcode == OP_LOAD);
                MemWrite_o = (opcode == OP_STORE);
                retire_o   = (opcode == OP_STORE) && mem_ready_i;
            end
            ST_WB: begin
                RegWrite_o = 1'b1;
                MemtoReg_o = (opcode == OP_LOAD);
                retire_o   = 1'b1;
            end
            default: ;
        endcase
    end

    assign illegal_o = illegal;
    assign state_o   = state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle vector table plus latency, async-reset and timeout sequences.
module tb_multicycle_ctrl;

    localparam logic [6:0] R   = 7'b0110011;
    localparam logic [6:0] I   = 7'b0010011;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;
    localparam logic [6:0] BR  = 7'b1100011;
    localparam logic [6:0] BAD = 7'b1111111;

    localparam logic [2:0] SI = 3'd0, SF = 3'd1, SD = 3'd2, SE = 3'd3, SM = 3'd4, SW = 3'd5;
    localparam logic [1:0] A_ADD = 2'b00, A_SUB = 2'b01, A_FN = 2'b10;

    logic       clk_i = 1'b0;
    logic       rst_i, start_i, halt_i, Zero_i, mem_ready_i;
    logic [6:0] Op_i;
    logic       PCWrite_o, IRWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, ALUSrc_o, RegWrite_o, Branch_o;
    logic [1:0] ALUOp_o;
    logic       retire_o, illegal_o;
    logic [2:0] state_o;
`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
    logic       timeout_o;
`endif

    int nvec = 0;
    int nerr = 0;

    multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .halt_i(halt_i),
        .Op_i(Op_i), .Zero_i(Zero_i), .mem_ready_i(mem_ready_i),
        .PCWrite_o(PCWrite_o), .IRWrite_o(IRWrite_o), .MemRead_o(MemRead_o),
        .MemWrite_o(MemWrite_o), .MemtoReg_o(MemtoReg_o), .ALUSrc_o(ALUSrc_o),
        .RegWrite_o(RegWrite_o), .Branch_o(Branch_o), .ALUOp_o(ALUOp_o),
        .retire_o(retire_o), .illegal_o(illegal_o),
`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
        .timeout_o(timeout_o),
`endif
        .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    // rsh = {rst, start, halt}; zr = {Zero, mem_ready}
    // ctl = {PCWrite, IRWrite, MemRead, MemWrite, MemtoReg, ALUSrc, RegWrite, Branch}; ri = {retire, illegal}
    typedef struct {
        string      nm;
        logic [2:0] rsh;
        logic [6:0] op;
        logic [1:0] zr;
        logic [2:0] st;
        logic [7:0] ctl;
        logic [1:0] alu;
        logic [1:0] ri;
    } vec_t;

    vec_t tv[$];

    task automatic add(input string nm, input logic [2:0] rsh, input logic [6:0] op, input logic [1:0] zr,
                       input logic [2:0] st, input logic [7:0] ctl, input logic [1:0] alu, input logic [1:0] ri);
        vec_t v;
        v.nm = nm; v.rsh = rsh; v.op = op; v.zr = zr;
        v.st = st; v.ctl = ctl; v.alu = alu; v.ri = ri;
        tv.push_back(v);
    endtask

    task automatic check(input string nm, input logic [2:0] st, input logic [7:0] ctl,
                         input logic [1:0] alu, input logic [1:0] ri);
        logic [7:0] act_ctl;
        act_ctl = {PCWrite_o, IRWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, ALUSrc_o, RegWrite_o, Branch_o};
        nvec++;
        if ({state_o, act_ctl, ALUOp_o, retire_o, illegal_o} !== {st, ctl, alu, ri}) begin
            nerr++;
            $display("FAIL %s: got st=%0d ctl=%b alu=%b ret/ill=%b, want st=%0d ctl=%b alu=%b ret/ill=%b",
                     nm, state_o, act_ctl, ALUOp_o, {retire_o, illegal_o}, st, ctl, alu, ri);
        end
    endtask

    // Runs one instruction from IDLE with halt held (only honoured at retire) and counts non-IDLE cycles.
    task automatic latency(input string nm, input logic [6:0] op, input int exp_cycles);
        int  n;
        bit  done;
        @(negedge clk_i);
        start_i = 1'b1; halt_i = 1'b1; mem_ready_i = 1'b1; Zero_i = 1'b0; Op_i = op;
        @(negedge clk_i);
        start_i = 1'b0;
        n = 0;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            #1;
            if (state_o == SI) done = 1'b1;
            else begin
                n++;
                @(negedge clk_i);
            end
        end
        nvec++;
        if (!done || n != exp_cycles) begin
            nerr++;
            $display("FAIL %s: got %0d cycles (returned=%0d), want %0d", nm, n, done, exp_cycles);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, vectors=%0d", nvec);
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1; start_i = 1'b0; halt_i = 1'b0; Op_i = R; Zero_i = 1'b0; mem_ready_i = 1'b1;

        add("reset",          3'b100, R,   2'b01, SI, 8'b0000_0000, A_ADD, 2'b00);
        add("idle_hold",      3'b000, R,   2'b01, SI, 8'b0000_0000, A_ADD, 2'b00);
        add("idle_halt_ign",  3'b001, R,   2'b01, SI, 8'b0000_0000, A_ADD, 2'b00);
        add("idle_start",     3'b010, R,   2'b01, SI, 8'b0000_0000, A_ADD, 2'b00);
        add("r_fetch",        3'b000, R,   2'b01, SF, 8'b1110_0000, A_ADD, 2'b00);
        add("r_decode",       3'b010, R,   2'b01, SD, 8'b0000_0000, A_ADD, 2'b00);
        add("r_exec_latched", 3'b000, BAD, 2'b01, SE, 8'b0000_0000, A_FN,  2'b00);
        add("r_wb",           3'b000, BAD, 2'b01, SW, 8'b0000_0010, A_ADD, 2'b10);
        add("i_fetch_wait",   3'b001, I,   2'b00, SF, 8'b0010_0000, A_ADD, 2'b00);
        add("i_fetch",        3'b000, I,   2'b01, SF, 8'b1110_0000, A_ADD, 2'b00);
        add("i_decode",       3'b000, I,   2'b01, SD, 8'b0000_0000, A_ADD, 2'b00);
        add("i_exec",         3'b000, LD,  2'b01, SE, 8'b0000_0100, A_FN,  2'b00);
        add("i_wb",           3'b000, LD,  2'b01, SW, 8'b0000_0010, A_ADD, 2'b10);
        add("ld_fetch",       3'b000, LD,  2'b01, SF, 8'b1110_0000, A_ADD, 2'b00);
        add("ld_decode",      3'b000, LD,  2'b01, SD, 8'b0000_0000, A_ADD, 2'b00);
        add("ld_exec",        3'b000, ST,  2'b01, SE, 8'b0000_0100, A_ADD, 2'b00);
        add("ld_mem_w1",      3'b000, ST,  2'b00, SM, 8'b0010_0100, A_ADD, 2'b00);
        add("ld_mem_w2",      3'b000, ST,  2'b00, SM, 8'b0010_0100, A_ADD, 2'b00);
        add("ld_mem_w3",      3'b000, ST,  2'b00, SM, 8'b0010_0100, A_ADD, 2'b00);
        add("ld_mem_rdy",     3'b000, ST,  2'b01, SM, 8'b0010_0100, A_ADD, 2'b00);
        add("ld_wb",          3'b000, ST,  2'b01, SW, 8'b0000_1010, A_ADD, 2'b10);
        add("st_fetch",       3'b000, ST,  2'b01, SF, 8'b1110_0000, A_ADD, 2'b00);
        add("st_decode",      3'b000, ST,  2'b01, SD, 8'b0000_0000, A_ADD, 2'b00);
        add("st_exec",        3'b000, LD,  2'b01, SE, 8'b0000_0100, A_ADD, 2'b00);
        add("st_mem_wait",    3'b001, LD,  2'b00, SM, 8'b0001_0100, A_ADD, 2'b00);
        add("st_mem_halt",    3'b001, LD,  2'b01, SM, 8'b0001_0100, A_ADD, 2'b10);
        add("st_halted_idle", 3'b000, BR,  2'b01, SI, 8'b0000_0000, A_ADD, 2'b00);
        add("br_start",       3'b010, BR,  2'b01, SI, 8'b0000_0000, A_ADD, 2'b00);
        add("br1_fetch",      3'b000, BR,  2'b01, SF, 8'b1110_0000, A_ADD, 2'b00);
        add("br1_decode",     3'b000, BR,  2'b01, SD, 8'b0000_0000, A_ADD, 2'b00);
        add("br1_exec_z1",    3'b000, R,   2'b11, SE, 8'b1000_0001, A_SUB, 2'b10);
        add("br2_fetch",      3'b000, BR,  2'b01, SF, 8'b1110_0000, A_ADD, 2'b00);
        add("br2_decode",     3'b000, BR,  2'b01, SD, 8'b0000_0000, A_ADD, 2'b00);
        add("br2_exec_z0",    3'b000, R,   2'b01, SE, 8'b0000_0001, A_SUB, 2'b10);
        add("bad_fetch",      3'b000, BAD, 2'b01, SF, 8'b1110_0000, A_ADD, 2'b00);
        add("bad_decode",     3'b000, BAD, 2'b01, SD, 8'b0000_0000, A_ADD, 2'b10);
        add("bad_then_fetch", 3'b000, R,   2'b01, SF, 8'b1110_0000, A_ADD, 2'b01);
        add("ill_r_decode",   3'b000, R,   2'b01, SD, 8'b0000_0000, A_ADD, 2'b01);
        add("ill_r_exec",     3'b000, R,   2'b01, SE, 8'b0000_0000, A_FN,  2'b01);
        add("ill_r_wb_halt",  3'b001, R,   2'b01, SW, 8'b0000_0010, A_ADD, 2'b11);
        add("ill_idle_start", 3'b010, R,   2'b01, SI, 8'b0000_0000, A_ADD, 2'b01);
        add("rst_fetch_wait", 3'b000, R,   2'b00, SF, 8'b0010_0000, A_ADD, 2'b01);
        add("rst_mid_fetch",  3'b100, R,   2'b00, SI, 8'b0000_0000, A_ADD, 2'b00);
        add("post_reset",     3'b000, R,   2'b00, SI, 8'b0000_0000, A_ADD, 2'b00);

        foreach (tv[k]) begin
            @(negedge clk_i);
            {rst_i, start_i, halt_i} = tv[k].rsh;
            Op_i = tv[k].op;
            {Zero_i, mem_ready_i} = tv[k].zr;
            #1;
            check(tv[k].nm, tv[k].st, tv[k].ctl, tv[k].alu, tv[k].ri);
        end

        // Reset raised just after a clock edge while FETCH is waiting must clear MemRead_o before the next edge.
        @(negedge clk_i);
        start_i = 1'b1; mem_ready_i = 1'b0; Op_i = R;
        @(negedge clk_i);
        start_i = 1'b0;
        #1;
        check("async_pre_fetch", SF, 8'b0010_0000, A_ADD, 2'b00);
        @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1;
        check("async_rst_fetch", SI, 8'b0000_0000, A_ADD, 2'b00);
        #1 rst_i = 1'b0;

        latency("lat_r",      R,   4);
        latency("lat_i",      I,   4);
        latency("lat_load",   LD,  5);
        latency("lat_store",  ST,  4);
        latency("lat_branch", BR,  3);
        latency("lat_illegal", BAD, 2);
        halt_i = 1'b0;

`ifdef MULTICYCLE_CTRL_TIMEOUT_EN
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0; start_i = 1'b1; mem_ready_i = 1'b0; Op_i = R;
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (14) @(negedge clk_i);
        #1;
        nvec++;
        if (state_o !== SF || timeout_o !== 1'b0) begin
            nerr++;
            $display("FAIL to_wait15: got st=%0d timeout=%b, want st=%0d timeout=0", state_o, timeout_o, SF);
        end
        @(negedge clk_i);
        #1;
        nvec++;
        if (state_o !== SI || timeout_o !== 1'b1 || MemRead_o !== 1'b0) begin
            nerr++;
            $display("FAIL to_abort: got st=%0d timeout=%b memread=%b, want st=0 timeout=1 memread=0",
                     state_o, timeout_o, MemRead_o);
        end
        @(negedge clk_i);
        start_i = 1'b1; mem_ready_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        #1;
        nvec++;
        if (state_o !== SF || timeout_o !== 1'b1) begin
            nerr++;
            $display("FAIL to_sticky: got st=%0d timeout=%b, want st=%0d timeout=1", state_o, timeout_o, SF);
        end
        rst_i = 1'b1;
        #1;
        nvec++;
        if (state_o !== SI || timeout_o !== 1'b0) begin
            nerr++;
            $display("FAIL to_reset: got st=%0d timeout=%b, want st=0 timeout=0", state_o, timeout_o);
        end
        rst_i = 1'b0;
`endif

        @(negedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, memory-wait cycles allowed before abort (used only with timeout feature).
REQ-002 SHALL have port clk_i, input, 1, single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port start_i, input, 1, leave IDLE and begin fetching.
REQ-005 SHALL have port halt_i, input, 1, return to IDLE at the next instruction boundary.
REQ-006 SHALL have port Op_i, input, 7, opcode field of the instruction register.
REQ-007 SHALL have port Zero_i, input, 1, ALU zero flag for branch resolution.
REQ-008 SHALL have port mem_ready_i, input, 1, memory completes the current access this cycle.
REQ-009 SHALL have ports PCWrite_o, IRWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, ALUSrc_o, RegWrite_o, Branch_o, output, 1 each, datapath controls.
REQ-010 SHALL have port ALUOp_o, output, 2, ALU operation class.
REQ-011 SHALL have ports retire_o (output, 1, instruction-complete pulse), illegal_o (output, 1, sticky bad-opcode flag) and state_o (output, 3, current state encoding).

Function
REQ-012 SHALL implement states IDLE, FETCH, DECODE, EXEC, MEM, WB.
REQ-013 SHALL move IDLE->FETCH on start_i=1; all controls are 0 in IDLE.
REQ-014 In FETCH SHALL hold MemRead_o=1; on mem_ready_i=1 SHALL pulse IRWrite_o and PCWrite_o for that cycle and go to DECODE; otherwise stay in FETCH.
REQ-015 In DECODE SHALL latch Op_i into an internal opcode register; R/I/LOAD/STORE/BRANCH go to EXEC; any other opcode sets illegal_o, pulses retire_o and goes to FETCH (or IDLE if halt_i).
REQ-016 In EXEC SHALL drive ALUOp_o=FUNCT with ALUSrc_o=0 for R and ALUSrc_o=1 for I (then WB); ALUOp_o=ADD with ALUSrc_o=1 for LOAD/STORE (then MEM); ALUOp_o=SUB, ALUSrc_o=0, Branch_o=1, PCWrite_o=Zero_i for BRANCH (then retire).
REQ-017 In MEM SHALL hold MemRead_o=1 (LOAD) or MemWrite_o=1 (STORE) and ALUSrc_o=1 until mem_ready_i=1; LOAD then goes to WB; STORE retires.
REQ-018 In WB SHALL assert RegWrite_o=1 for one cycle, MemtoReg_o=1 only for LOAD, then retire.
REQ-019 Retire SHALL mean retire_o=1 for that cycle and next state FETCH, or IDLE if halt_i=1 in that cycle.
REQ-020 halt_i SHALL be ignored outside retire cycles; start_i SHALL be ignored outside IDLE.
REQ-021 Opcode decisions after DECODE SHALL use the latched opcode, never live Op_i.
REQ-022 Outputs SHALL be combinational from state plus latched opcode plus Zero_i/mem_ready_i as stated; unlisted controls are 0.
REQ-023 Instruction latency without wait states SHALL be: R/I 4 cycles, LOAD 5, STORE 4, BRANCH 3 (FETCH..final state inclusive).

Reset
REQ-024 rst_i=1 SHALL force IDLE, clear opcode register, illegal_o and timeout state immediately, regardless of clock.
REQ-025 Reset mid-access SHALL drop MemRead_o/MemWrite_o to 0 in the same cycle; no retire_o is produced.

Configuration
REQ-026 With MULTICYCLE_CTRL_TIMEOUT_EN defined, a 4-bit wait counter SHALL count FETCH/MEM cycles with mem_ready_i=0; on reaching MEM_TIMEOUT the access SHALL abort to IDLE and set a sticky timeout_o output (1 bit), cleared only by reset.
REQ-027 Without MULTICYCLE_CTRL_TIMEOUT_EN, the counter and timeout_o SHALL not exist and waits SHALL be unbounded.

Structure
REQ-028 A shared package SHALL hold opcode constants (R 0110011, I 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011), ALUOp encodings (ADD 00, SUB 01, FUNCT 10) and the state enumeration (IDLE 0 .. WB 5).
REQ-029 Single module; no sub-module required.

Verification
REQ-030 Reset, start_i=1, R-type 0110011, mem_ready_i=1 always -> states FETCH,DECODE,EXEC,WB; RegWrite_o=1 in cycle 4; retire_o in cycle 4.
REQ-031 LOAD with mem_ready_i low 3 cycles in MEM -> MemRead_o held 4 cycles; WB has MemtoReg_o=1, RegWrite_o=1.
REQ-032 BRANCH with Zero_i=1 then Zero_i=0 -> PCWrite_o=1 in EXEC for the first only; Branch_o=1 in both.
REQ-033 Op_i=1111111 in DECODE -> illegal_o=1 and stays 1; next state FETCH.
REQ-034 halt_i=1 during STORE retire -> IDLE next; rst_i pulse mid-FETCH -> IDLE and MemRead_o=0 asynchronously.
REQ-035 With MULTICYCLE_CTRL_TIMEOUT_EN and mem_ready_i=0 for 15 cycles in FETCH -> timeout_o=1, state IDLE.
